pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer_if.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 117 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the PLL/system side.
// force_relock is a single-cycle pulse with no ready; it only takes effect while ready is high.
interface pll_lock_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             force_relock;
    logic             pll_reset;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] relock_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [1:0]       state_dbg;

    modport master (
        input  pll_lock, force_relock,
        output pll_reset, sys_rst, ready, relock_cnt, timeout_cnt, state_dbg
    );

    modport slave (
        output pll_lock, force_relock,
        input  pll_reset, sys_rst, ready, relock_cnt, timeout_cnt, state_dbg
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock wait with timeout, lock stability and system reset release.
// Runs entirely on clkin; pll_lock is synchronized before use.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 50,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic                 clkin,
    input  logic                 reset,
    pll_lock_sequencer_if.master bus
);
    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CYC_W  = $clog2(MAX_C);

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ASSERT_RST = 2'd0,
        WAIT_LOCK  = 2'd1,
        STABLE     = 2'd2,
        RUN        = 2'd3
    } state_t;

    state_t           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [1:0]       lock_sync;
    logic             lock_s;
    logic             pll_reset_q;
    logic             sys_rst_q;
    logic             ready_q;
    logic [CNT_W-1:0] relock_q;
    logic [CNT_W-1:0] timeout_q;

    assign lock_s = lock_sync[1];

    // Outputs are set on the transition edge itself so each is a single flop.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= ASSERT_RST;
            cyc_cnt     <= '0;
            lock_sync   <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            relock_q    <= '0;
            timeout_q   <= '0;
        end else begin
            lock_sync <= {lock_sync[0], bus.pll_lock};
            case (state)
                ASSERT_RST: begin
                    if (cyc_cnt == RST_LAST) begin
                        state       <= WAIT_LOCK;
                        cyc_cnt     <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state   <= STABLE;
                        cyc_cnt <= '0;
                    end else if (cyc_cnt == TIMEOUT_LAST) begin
                        state       <= ASSERT_RST;
                        cyc_cnt     <= '0;
                        pll_reset_q <= 1'b1;
                        if (timeout_q != '1) timeout_q <= timeout_q + CNT_W'(1);
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                STABLE: begin
                    // A lock dropout is a glitch, not a timeout: just wait again.
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        cyc_cnt <= '0;
                    end else if (cyc_cnt == STABLE_LAST) begin
                        state     <= RUN;
                        cyc_cnt   <= '0;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s || bus.force_relock) begin
                        state       <= ASSERT_RST;
                        cyc_cnt     <= '0;
                        pll_reset_q <= 1'b1;
                        sys_rst_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        if (relock_q != '1) relock_q <= relock_q + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ASSERT_RST;
                    cyc_cnt     <= '0;
                    pll_reset_q <= 1'b1;
                    sys_rst_q   <= 1'b1;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.relock_cnt  = relock_q;
    assign bus.timeout_cnt = timeout_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST=4, TIMEOUT=20, STABLE=8, CNT_W=4.
// Edge numbers are counted from the first clkin edge after reset release.
module tb_pll_lock_sequencer;
    localparam int ST_ASSERT = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_STABLE = 2;
    localparam int ST_RUN    = 3;

    logic clkin = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecnt = 0;

    pll_lock_sequencer_if #(.CNT_W(4)) bus ();

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .CNT_W        (4)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    task automatic goto_edge(input int target);
        while (ecnt < target) begin
            @(posedge clkin);
            #1;
            ecnt++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, int'(bus.pll_reset), 1);
        check({tag, "_sys_rst"}, int'(bus.sys_rst), 1);
        check({tag, "_ready"}, int'(bus.ready), 0);
        check({tag, "_relock"}, int'(bus.relock_cnt), 0);
        check({tag, "_timeout"}, int'(bus.timeout_cnt), 0);
        check({tag, "_state"}, int'(bus.state_dbg), ST_ASSERT);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.force_relock = 1'b0;
        repeat (2) begin
            @(posedge clkin);
            #1;
        end
        check_reset_values(tag);
        reset = 1'b0;
        ecnt = 0;
    endtask

    initial begin
        bus.pll_lock = 1'b1;
        bus.force_relock = 1'b0;

        // Clean bring-up: ready exactly 13 edges after release.
        do_reset("rst1");
        for (int i = 1; i <= 13; i++) begin
            goto_edge(i);
            check("up_pll_reset", int'(bus.pll_reset), (i < 4) ? 1 : 0);
            check("up_sys_rst", int'(bus.sys_rst), (i < 13) ? 1 : 0);
            check("up_ready", int'(bus.ready), (i == 13) ? 1 : 0);
        end
        check("up_relock", int'(bus.relock_cnt), 0);
        check("up_timeout", int'(bus.timeout_cnt), 0);

        // No lock: 24-cycle period, 4-wide pll_reset, timeout count saturates at 15.
        bus.pll_lock = 1'b0;
        do_reset("rst2");
        for (int i = 1; i <= 16 * 24 + 4; i++) begin
            goto_edge(i);
            check("nl_pll_reset", int'(bus.pll_reset), ((i % 24) < 4) ? 1 : 0);
            check("nl_timeout", int'(bus.timeout_cnt), ((i / 24) > 15) ? 15 : (i / 24));
            check("nl_ready", int'(bus.ready), 0);
        end

        // Glitch during STABLE: STABLE entered at edge 8, lock lost edges 12..15.
        do_reset("rst3");
        goto_edge(5);
        bus.pll_lock = 1'b1;
        goto_edge(8);
        check("gl_state_stable", int'(bus.state_dbg), ST_STABLE);
        goto_edge(12);
        bus.pll_lock = 1'b0;
        goto_edge(14);
        check("gl_still_stable", int'(bus.state_dbg), ST_STABLE);
        goto_edge(15);
        check("gl_back_wait", int'(bus.state_dbg), ST_WAIT);
        bus.pll_lock = 1'b1;
        goto_edge(18);
        check("gl_restable", int'(bus.state_dbg), ST_STABLE);
        goto_edge(25);
        check("gl_ready_early", int'(bus.ready), 0);
        goto_edge(26);
        check("gl_ready", int'(bus.ready), 1);
        check("gl_sys_rst", int'(bus.sys_rst), 0);
        check("gl_relock", int'(bus.relock_cnt), 0);
        check("gl_timeout", int'(bus.timeout_cnt), 0);

        // Lock loss in RUN: outputs react on the 3rd edge after pll_lock falls.
        goto_edge(30);
        bus.pll_lock = 1'b0;
        goto_edge(32);
        check("ll_ready_hold", int'(bus.ready), 1);
        check("ll_pll_reset_hold", int'(bus.pll_reset), 0);
        goto_edge(33);
        check("ll_sys_rst", int'(bus.sys_rst), 1);
        check("ll_ready", int'(bus.ready), 0);
        check("ll_pll_reset", int'(bus.pll_reset), 1);
        check("ll_relock", int'(bus.relock_cnt), 1);
        bus.pll_lock = 1'b1;
        goto_edge(36);
        check("ll_pulse_end", int'(bus.pll_reset), 1);
        goto_edge(37);
        check("ll_pulse_off", int'(bus.pll_reset), 0);
        goto_edge(45);
        check("ll_ready_early", int'(bus.ready), 0);
        goto_edge(46);
        check("ll_ready_back", int'(bus.ready), 1);
        check("ll_timeout", int'(bus.timeout_cnt), 0);

        // force_relock coincident with lock_s falling (lock_s seen low at edge 53).
        goto_edge(50);
        bus.pll_lock = 1'b0;
        goto_edge(52);
        check("sim_run", int'(bus.state_dbg), ST_RUN);
        bus.force_relock = 1'b1;
        goto_edge(53);
        bus.force_relock = 1'b0;
        check("sim_state", int'(bus.state_dbg), ST_ASSERT);
        check("sim_relock", int'(bus.relock_cnt), 2);
        goto_edge(54);
        check("sim_relock_once", int'(bus.relock_cnt), 2);
        goto_edge(58);
        check("sim_wait", int'(bus.state_dbg), ST_WAIT);
        bus.pll_lock = 1'b1;
        bus.force_relock = 1'b1;
        goto_edge(59);
        bus.force_relock = 1'b0;
        check("wf_state", int'(bus.state_dbg), ST_WAIT);
        check("wf_pll_reset", int'(bus.pll_reset), 0);
        check("wf_relock", int'(bus.relock_cnt), 2);
        goto_edge(61);
        check("wf_stable", int'(bus.state_dbg), ST_STABLE);
        goto_edge(69);
        check("wf_ready", int'(bus.ready), 1);

        // Build nonzero counters, then reset mid-STABLE.
        goto_edge(70);
        bus.pll_lock = 1'b0;
        goto_edge(73);
        check("mr_relock", int'(bus.relock_cnt), 3);
        goto_edge(97);
        check("mr_timeout", int'(bus.timeout_cnt), 1);
        check("mr_pll_reset", int'(bus.pll_reset), 1);
        goto_edge(100);
        bus.pll_lock = 1'b1;
        goto_edge(103);
        check("mr_stable", int'(bus.state_dbg), ST_STABLE);
        goto_edge(106);
        check("mr_stable_hold", int'(bus.state_dbg), ST_STABLE);
        reset = 1'b1;
        goto_edge(107);
        check_reset_values("mr_reset");
        reset = 1'b0;
        ecnt = 0;
        goto_edge(12);
        check("mr_ready_early", int'(bus.ready), 0);
        goto_edge(13);
        check("mr_ready", int'(bus.ready), 1);
        check("mr_sys_rst", int'(bus.sys_rst), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
